// File: rtl/sevenseg_scan_driver_if.sv
// rtl/sevenseg_scan_driver_if.sv - digit inputs, display controls and scanned display outputs
interface sevenseg_scan_driver_if;
  logic [3:0] Tenths_Seconds;
  logic [3:0] Ones_Seconds;
  logic [3:0] Tens_Seconds;
  logic [3:0] Minutes;
  logic       blank_lz;
  logic       blink_en;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  modport master (
    output Tenths_Seconds, Ones_Seconds, Tens_Seconds, Minutes, blank_lz, blink_en,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  Tenths_Seconds, Ones_Seconds, Tens_Seconds, Minutes, blank_lz, blink_en,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/sevenseg_scan_driver.sv
// rtl/sevenseg_scan_driver.sv - 4-digit common-anode 7-segment scan driver with per-frame digit snapshot
module sevenseg_scan_driver #(
  parameter int REFRESH_DIV  = 2500,
  parameter int BLINK_FRAMES = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  sevenseg_scan_driver_if.slave  bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]     presc;
  logic [1:0]        idx;
  logic              primed;
  logic [3:0][3:0]   snap;
  logic [BW-1:0]     blink_cnt;
  logic              phase;
  logic              frame_phase;

  logic [3:0]        an_q;
  logic [6:0]        seg_q;
  logic              dp_q;
  logic              tick_q;

  logic              step;
  logic [1:0]        next_idx;
  logic              frame_start;
  logic [3:0][3:0]   dig;
  logic [3:0]        sel_digit;
  logic              blank_pos;
  logic              phase_now;
  logic [3:0]        an_n;
  logic [6:0]        seg_n;
  logic              dp_n;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // The first edge after reset is an unconditional step onto index 0.
  always_comb begin
    step        = !primed || (presc == PRESC_LAST);
    next_idx    = primed ? (idx + 2'd1) : 2'd0;
    frame_start = step && (next_idx == 2'd0);

    dig = frame_start ? {bus.Minutes, bus.Tens_Seconds, bus.Ones_Seconds, bus.Tenths_Seconds}
                      : snap;
    sel_digit = dig[next_idx];

    blank_pos = bus.blank_lz &&
                (((next_idx == 2'd3) && (dig[3] == 4'd0)) ||
                 ((next_idx == 2'd2) && (dig[3] == 4'd0) && (dig[2] == 4'd0)));

    seg_n = blank_pos ? 7'h7F : decode(sel_digit);
    dp_n  = blank_pos ? 1'b1 : !((next_idx == 2'd1) || (next_idx == 2'd3));

    // The phase in force for a frame is the one held when that frame started.
    phase_now = frame_start ? phase : frame_phase;
    an_n      = (bus.blink_en && phase_now) ? 4'b1111 : ~(4'b0001 << next_idx);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc       <= '0;
      idx         <= 2'd0;
      primed      <= 1'b0;
      snap        <= '0;
      blink_cnt   <= '0;
      phase       <= 1'b0;
      frame_phase <= 1'b0;
      an_q        <= 4'b1111;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      tick_q <= frame_start;

      if (step) begin
        presc  <= '0;
        idx    <= next_idx;
        primed <= 1'b1;
        an_q   <= an_n;
        seg_q  <= seg_n;
        dp_q   <= dp_n;
      end else begin
        presc  <= presc + PW'(1);
      end

      if (frame_start) begin
        snap        <= dig;
        frame_phase <= phase;
      end

      if (!bus.blink_en) begin
        blink_cnt   <= '0;
        phase       <= 1'b0;
        frame_phase <= 1'b0;
      end else if (frame_start) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          phase     <= !phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// tb/tb_sevenseg_scan_driver.sv - scoreboard bench for the 7-segment scan driver
module tb_sevenseg_scan_driver;
  localparam int RD = 4;
  localparam int BF = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  sevenseg_scan_driver_if bus ();

  sevenseg_scan_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [11:0] exp_q[$];
  logic [11:0] last_exp = 12'hFFF;
  logic [6:0]  seg_tab[16];
  logic [3:0]  m_dig[4];
  int          en_frames = 0;
  bit          f_phase = 1'b0;
  bit          running = 1'b0;
  int          cyc = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: a new display word is due every RD cycles; in between, outputs must hold.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      cyc = 0;
    end else if (running) begin
      if (cyc % RD == 0) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL step_queue: got empty queue expected an entry at cycle %0d", cyc);
        end else begin
          last_exp = exp_q.pop_front();
        end
        check("step_out", {bus.an, bus.seg, bus.dp}, last_exp);
      end else begin
        check("hold_out", {bus.an, bus.seg, bus.dp}, last_exp);
      end
      check("frame_tick", bus.frame_tick, (cyc % (4 * RD) == 0));
      cyc++;
    end
  end

  // Reference model: expected display word for the position about to be shown.
  task automatic push_step(input int pos);
    logic [11:0] e;
    int  lz;
    bit  blank_an;
    bit  blanked;
    if (pos == 0) begin
      m_dig[0] = bus.Tenths_Seconds;
      m_dig[1] = bus.Ones_Seconds;
      m_dig[2] = bus.Tens_Seconds;
      m_dig[3] = bus.Minutes;
      if (bus.blink_en) begin
        f_phase = ((en_frames / BF) % 2) == 1;
        en_frames++;
      end else begin
        en_frames = 0;
        f_phase = 1'b0;
      end
    end else if (!bus.blink_en) begin
      en_frames = 0;
      f_phase = 1'b0;
    end
    blank_an = bus.blink_en && f_phase;
    lz = 4;
    if (bus.blank_lz && m_dig[3] == 4'd0) begin
      lz = 3;
      if (m_dig[2] == 4'd0) lz = 2;
    end
    blanked = (pos >= lz);
    e[11:8] = blank_an ? 4'hF : ~(4'b0001 << pos);
    e[7:1]  = blanked ? 7'h7F : seg_tab[m_dig[pos]];
    e[0]    = blanked ? 1'b1 : !(pos == 1 || pos == 3);
    exp_q.push_back(e);
  endtask

  task automatic frame(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o,
                       input logic [3:0] te, input bit blz, input bit ben, input bit churn,
                       input int drop_pos, input int npos);
    for (int pos = 0; pos < npos; pos++) begin
      if (pos == 0) begin
        bus.Minutes = m;
        bus.Tens_Seconds = t;
        bus.Ones_Seconds = o;
        bus.Tenths_Seconds = te;
      end else if (churn) begin
        bus.Minutes = 4'($urandom_range(15));
        bus.Tens_Seconds = 4'($urandom_range(15));
        bus.Ones_Seconds = 4'($urandom_range(15));
        bus.Tenths_Seconds = 4'($urandom_range(15));
      end
      bus.blank_lz = blz;
      bus.blink_en = ben && (pos < drop_pos);
      push_step(pos);
      repeat (RD) @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_an"}, bus.an, 4'hF);
    check({tag, "_seg"}, bus.seg, 7'h7F);
    check({tag, "_dp"}, bus.dp, 1'b1);
    check({tag, "_tick"}, bus.frame_tick, 1'b0);
  endtask

  initial begin
    logic [3:0] rm;
    logic [3:0] rt;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    bus.Minutes = 4'd1;
    bus.Tens_Seconds = 4'd2;
    bus.Ones_Seconds = 4'd3;
    bus.Tenths_Seconds = 4'd4;
    bus.blank_lz = 1'b0;
    bus.blink_en = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    running = 1'b1;

    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4, 4);
    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4, 4);

    for (int i = 0; i < 3; i++)
      frame(4'($urandom_range(9)), 4'($urandom_range(5)), 4'($urandom_range(9)),
            4'($urandom_range(9)), 1'b0, 1'b0, 1'b1, 4, 4);

    frame(4'd0, 4'd0, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0, 4, 4);
    frame(4'd0, 4'd3, 4'd5, 4'd9, 1'b1, 1'b0, 1'b0, 4, 4);
    frame(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4, 4);

    frame(4'd1, 4'd2, 4'd3, 4'hC, 1'b0, 1'b0, 1'b0, 4, 4);
    for (int i = 0; i < 3; i++)
      frame(4'($urandom_range(15)), 4'($urandom_range(15)), 4'($urandom_range(15)),
            4'($urandom_range(15)), 1'b0, 1'b0, 1'b1, 4, 4);

    for (int i = 0; i < 6; i++)
      frame(4'($urandom_range(9)), 4'($urandom_range(5)), 4'($urandom_range(9)),
            4'($urandom_range(9)), 1'b0, 1'b1, 1'b1, 4, 4);
    frame(4'd2, 4'd1, 4'd0, 4'd7, 1'b0, 1'b1, 1'b0, 2, 4);
    frame(4'd2, 4'd1, 4'd0, 4'd7, 1'b0, 1'b0, 1'b0, 4, 4);

    for (int i = 0; i < 10; i++) begin
      rm = $urandom_range(1) ? 4'd0 : 4'($urandom_range(15));
      rt = $urandom_range(1) ? 4'd0 : 4'($urandom_range(15));
      frame(rm, rt, 4'($urandom_range(15)), 4'($urandom_range(15)),
            1'($urandom_range(1)), 1'($urandom_range(1)), 1'b1, 4, 4);
    end

    frame(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4, 2);
    push_step(2);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_state("async_reset");
    repeat (2) @(negedge clk);
    check_reset_state("held_reset");
    en_frames = 0;
    f_phase = 1'b0;
    reset = 1'b0;

    frame(4'd0, 4'd0, 4'd8, 4'd6, 1'b1, 1'b0, 1'b0, 4, 4);
    frame(4'd9, 4'd5, 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 4, 4);

    running = 1'b0;
    repeat (2) @(negedge clk);
    check("queue_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
Downstream consumer of the stopwatch counter. It takes the four BCD digits (minutes, tens of seconds, ones of seconds, tenths) and drives a 4-digit common-anode 7-segment display by time-multiplexing. Digits are snapshotted once per frame so the display never tears. The block also provides leading-zero blanking, decimal points, an invalid-digit indicator and whole-display blinking.

Parameters:
REFRESH_DIV, 2500, clock cycles each digit stays lit (minimum 2)
BLINK_FRAMES, 50, frames per blink half-period (minimum 1)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
Tenths_Seconds  input  4  BCD tenths digit (display position 0, rightmost)
Ones_Seconds  input  4  BCD ones-of-seconds digit (position 1)
Tens_Seconds  input  4  BCD tens-of-seconds digit (position 2)
Minutes  input  4  BCD minutes digit (position 3, leftmost)
blank_lz  input  1  1 = blank leading zeros
blink_en  input  1  1 = blink the whole display
an  output  4  anode enables, active low, one-hot-low
seg  output  7  segments {g,f,e,d,c,b,a}, active low
dp  output  1  decimal point, active low
frame_tick  output  1  one-cycle pulse at each frame start

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. Prescaler=0, scan index=0, blink counter=0, blink phase=0 (visible). Snapshot digits are all 0.
- Prescaler: counts 0..REFRESH_DIV-1. Reaching terminal count is the "step".
  - On a step, scan index advances 0→1→2→3→0 (2-bit wrap).
  - The first cycle after reset deasserts is also treated as a step to index 0.
- Frame start: any step that lands on index 0 (including the post-reset step).
  - Latch all four input digits into the snapshot on that edge.
  - Pulse frame_tick high for exactly one cycle, on that same edge.
- Output registers: all outputs are registered.
  - On a step, an/seg/dp update on the same edge to the new index.
  - At frame start, digit 0 is decoded from the input values being captured.
  - Between steps, outputs hold their values.
- Anode: an = ~(4'b0001 << index).
- Decode (hex, active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Any value 10..15 shows a dash, 3F.
  - Blank is 7F.
- Leading-zero blanking (blank_lz=1, evaluated on the snapshot):
  - Position 3 is blank if Minutes==0.
  - Position 2 is blank if Tens_Seconds==0 and position 3 is blank.
  - Positions 1 and 0 are never blanked.
  - A blanked position drives seg=7F and dp=1; its anode still scans.
- Decimal point: dp=0 at position 1 (separates seconds from tenths) and at position 3 (minute separator), unless that position is blanked. dp=1 otherwise.
- Blink:
  - Blink counter increments on each frame_tick and wraps at BLINK_FRAMES-1.
  - Blink phase toggles on each wrap.
  - When blink_en=1 and phase=1, an is forced to 1111; seg and dp are still computed.
  - When blink_en=0, phase is forced to 0 and the counter is cleared, so re-enabling always starts visible.
- Input changes mid-frame have no effect until the next frame start.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). Scanning restarts at index 0 after release.

Test Plan:
- REFRESH_DIV=4, reset 3 cycles, inputs M=1, T=2, O=3, t=4:
  - First edge after release gives an=1110, seg=19, frame_tick=1.
  - Then every 4 cycles: an=1101 seg=30 dp=0; an=1011 seg=24 dp=1; an=0111 seg=79 dp=0.
  - Wraps back to 1110 with frame_tick.
- Snapshot: change Ones_Seconds 3→7 while index=2 → position 1 still shows 30 for the rest of the frame; shows 78 only in the next frame.
- blank_lz=1 with M=0, T=0, O=5, t=9:
  - Positions 3 and 2 show seg=7F, dp=1.
  - Position 1 shows 12 with dp=0; position 0 shows 10.
  - With M=0, T=3, only position 3 is blank.
- Tenths_Seconds=4'hC → position 0 shows 3F; the other positions decode normally.
- blink_en=1, BLINK_FRAMES=2:
  - an active for 2 frames, then 1111 for 2 frames, repeating.
  - Dropping blink_en immediately restores scanning on the next step.
- Assert reset while index=2 mid-count:
  - Outputs go to 1111/7F/1 without waiting for a clock edge.
  - After release, the first frame_tick occurs one cycle later at index 0.
